// File: rtl/fir_core.sv
// rtl/fir_core.sv - 11-tap signed FIR engine: AXI-Lite config, AXI-Stream in/out, external tap/data SRAMs
module fir_core #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    input  logic [pDATA_WIDTH-1:0] data_Do
);
    localparam int CW = $clog2(Tape_Num + 1);
    localparam logic [CW-1:0] NTAP   = CW'(Tape_Num);
    localparam logic [CW-1:0] LAST_K = CW'(Tape_Num - 1);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_LO    = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_HI    = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   ap_start_q, ap_start_d, ap_done_q, ap_done_d, ap_idle_q, ap_idle_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d, out_cnt_q, out_cnt_d, acc_q, acc_d;
    logic [CW-1:0]          ptr_q, ptr_d, cnt_q, cnt_d, didx_q, didx_d;
    logic                   mac_v_q, mac_v_d;
    logic                   ss_tready_q, ss_tready_d, sm_tvalid_q, sm_tvalid_d, sm_tlast_q, sm_tlast_d;
    logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d, rdata_q, rdata_d;
    logic                   awready_q, awready_d, arready_q, arready_d;
    logic                   rd_s1_q, rd_s1_d, rd_tap_q, rd_tap_d, rvalid_q, rvalid_d;
    logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic wr_fire, rd_fire, aw_is_tap, ar_is_tap, rd_is_tap, mac_issue, unused_ok;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign wr_fire   = awready_q & awvalid & wvalid;
    assign rd_fire   = arready_q & arvalid;
    assign aw_is_tap = (awaddr >= TAP_LO) && (awaddr <= TAP_HI) && (awaddr[1:0] == 2'b00);
    assign ar_is_tap = (araddr >= TAP_LO) && (araddr <= TAP_HI) && (araddr[1:0] == 2'b00);
    assign rd_is_tap = (rd_addr_q >= TAP_LO) && (rd_addr_q <= TAP_HI) && (rd_addr_q[1:0] == 2'b00);
    assign mac_issue = (state_q == S_MAC) && (cnt_q < NTAP);
    assign unused_ok = ss_tlast;

    // Read and write handshakes never share a cycle, so the tap SRAM port is never contended.
    always_comb begin
        awready_d = awvalid & wvalid & ~awready_q;
        arready_d = arvalid & ~arready_q & ~rd_s1_q & ~rvalid_q & ~awready_d;
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (mac_issue) begin
            tap_EN = 1'b1;
            tap_A  = word_addr(cnt_q);
        end else if (wr_fire && aw_is_tap && ap_idle_q) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - TAP_LO;
            tap_Di = wdata;
        end else if (rd_fire && ar_is_tap && ap_idle_q) begin
            tap_EN = 1'b1;
            tap_A  = araddr - TAP_LO;
        end
    end

    always_comb begin
        data_EN = 1'b0;
        data_WE = 4'h0;
        data_A  = '0;
        data_Di = '0;
        if (state_q == S_CLEAR) begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(cnt_q);
        end else if (state_q == S_WAIT_IN && ss_tvalid && ss_tready_q) begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(ptr_q);
            data_Di = ss_tdata;
        end else if (mac_issue) begin
            data_EN = 1'b1;
            data_A  = word_addr(didx_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        ap_done_d   = ap_done_q;
        ap_idle_d   = ap_idle_q;
        len_d       = len_q;
        out_cnt_d   = out_cnt_q;
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        didx_d      = didx_q;
        mac_v_d     = 1'b0;
        ss_tready_d = ss_tready_q;
        sm_tvalid_d = sm_tvalid_q;
        sm_tdata_d  = sm_tdata_q;
        sm_tlast_d  = sm_tlast_q;
        ap_start_d  = 1'b0;

        if (wr_fire && ap_idle_q && awaddr == ADDR_LEN)
            len_d = wdata;
        if (wr_fire && ap_idle_q && awaddr == ADDR_CTRL && wdata[0])
            ap_start_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (ap_start_q) begin
                    state_d   = S_CLEAR;
                    ap_idle_d = 1'b0;
                    ap_done_d = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = '0;
                    out_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_K) begin
                    cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_WAIT_IN;
                        ss_tready_d = 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                if (ss_tvalid && ss_tready_q) begin
                    ss_tready_d = 1'b0;
                    state_d     = S_MAC;
                    cnt_d       = '0;
                    didx_d      = ptr_q;
                    acc_d       = '0;
                end
            end
            S_MAC: begin
                // Reads issued at cnt_q are consumed one cycle later when mac_v_q is set.
                if (cnt_q < NTAP) begin
                    cnt_d   = cnt_q + CW'(1);
                    mac_v_d = 1'b1;
                    didx_d  = (didx_q == '0) ? LAST_K : didx_q - CW'(1);
                end
                if (mac_v_q)
                    acc_d = acc_q + tap_Do * data_Do;
                if (cnt_q == NTAP) begin
                    state_d     = S_OUT;
                    sm_tvalid_d = 1'b1;
                    sm_tdata_d  = acc_d;
                    sm_tlast_d  = (out_cnt_q == len_q - pDATA_WIDTH'(1));
                end
            end
            S_OUT: begin
                if (sm_tready) begin
                    sm_tvalid_d = 1'b0;
                    sm_tlast_d  = 1'b0;
                    ptr_d       = (ptr_q == LAST_K) ? '0 : ptr_q + CW'(1);
                    out_cnt_d   = out_cnt_q + pDATA_WIDTH'(1);
                    if (sm_tlast_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_WAIT_IN;
                        ss_tready_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                ap_done_d = 1'b1;
                ap_idle_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_s1_d   = rd_fire;
        rd_addr_d = rd_addr_q;
        rd_tap_d  = rd_tap_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_fire) begin
            rd_addr_d = araddr;
            rd_tap_d  = ap_idle_q;
        end
        if (rd_s1_q) begin
            rvalid_d = 1'b1;
            if (rd_addr_q == ADDR_CTRL)
                rdata_d = pDATA_WIDTH'({ap_idle_q, ap_done_q, ap_start_q});
            else if (rd_addr_q == ADDR_LEN)
                rdata_d = len_q;
            else if (rd_is_tap)
                rdata_d = rd_tap_q ? tap_Do : '1;
            else
                rdata_d = '0;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= S_IDLE;
            ap_start_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_idle_q   <= 1'b1;
            len_q       <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            didx_q      <= '0;
            mac_v_q     <= 1'b0;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            rd_s1_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_tap_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ap_start_q  <= ap_start_d;
            ap_done_q   <= ap_done_d;
            ap_idle_q   <= ap_idle_d;
            len_q       <= len_d;
            out_cnt_q   <= out_cnt_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            didx_q      <= didx_d;
            mac_v_q     <= mac_v_d;
            ss_tready_q <= ss_tready_d;
            sm_tvalid_q <= sm_tvalid_d;
            sm_tdata_q  <= sm_tdata_d;
            sm_tlast_q  <= sm_tlast_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            rd_s1_q     <= rd_s1_d;
            rd_addr_q   <= rd_addr_d;
            rd_tap_q    <= rd_tap_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = awready_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ss_tready = ss_tready_q;
    assign sm_tvalid = sm_tvalid_q;
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_fir_core.sv
// tb/tb_fir_core.sv - directed bench for fir_core with behavioural tap/data SRAMs
module tb_fir_core;
    localparam int NT = 11;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
    logic [31:0] ss_tdata = '0;
    logic        sm_tvalid, sm_tlast, sm_tready = 1'b0;
    logic [31:0] sm_tdata;
    logic [3:0]  tap_WE, data_WE;
    logic        tap_EN, data_EN;
    logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
    logic [11:0] tap_A, data_A;

    logic [31:0] tap_mem  [NT];
    logic [31:0] data_mem [NT];

    int tests = 0;
    int fails = 0;
    int tap_int [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int imp_exp [12] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0};
    logic [31:0] xq[$];
    logic [31:0] yq[$];

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;
    reg_vec_t vec[$];

    fir_core dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        if (tap_EN && int'(tap_A[5:2]) < NT) begin
            if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[5:2]];
        end
        if (data_EN && int'(data_A[5:2]) < NT) begin
            if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
            data_Do <= data_mem[data_A[5:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout", name);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int c = 0;
        @(negedge axis_clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge axis_clk);
        while (!awready && c < 20) begin @(negedge axis_clk); c++; end
        if (!awready) tmo("axi_write");
        @(negedge axis_clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int c = 0;
        d = '0;
        @(negedge axis_clk);
        araddr = a; arvalid = 1'b1;
        @(negedge axis_clk);
        while (!arready && c < 20) begin @(negedge axis_clk); c++; end
        if (!arready) tmo("axi_read_ar");
        @(negedge axis_clk);
        arvalid = 1'b0;
        c = 0;
        while (!rvalid && c < 20) begin @(negedge axis_clk); c++; end
        if (!rvalid) tmo("axi_read_r");
        d = rdata;
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
    endtask

    task automatic build_expected();
        yq.delete();
        for (int n = 0; n < xq.size(); n++) begin
            int acc = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0) acc += tap_int[k] * int'(xq[n - k]);
            yq.push_back(32'(acc));
        end
    endtask

    task automatic wait_done(input string name);
        logic [31:0] rd = '0;
        for (int i = 0; i < 60; i++) begin
            axi_read(12'h000, rd);
            if (rd[1]) break;
        end
        chk(name, rd, 32'h6);
        chk({name, "_no_extra_out"}, {31'b0, sm_tvalid}, 32'h0);
    endtask

    task automatic stream_only(input bit bp, input string name);
        int n = xq.size();
        fork
            begin : feeder
                for (int i = 0; i < n; i++) begin
                    int c = 0;
                    @(negedge axis_clk);
                    ss_tvalid = 1'b1; ss_tdata = xq[i]; ss_tlast = (i == n - 1);
                    while (!ss_tready && c < 200) begin @(negedge axis_clk); c++; end
                    if (!ss_tready) begin tmo({name, "_feed"}); break; end
                end
                @(negedge axis_clk);
                ss_tvalid = 1'b0; ss_tlast = 1'b0;
            end
            begin : collector
                int got = 0;
                int c = 0;
                bit stall = 1'b0;
                logic [31:0] held = '0;
                while (got < n && c < n * 60 + 200) begin
                    @(negedge axis_clk);
                    c++;
                    if (stall) begin
                        tests++;
                        if (!sm_tvalid || sm_tdata !== held) begin
                            fails++;
                            $display("FAIL %s_hold: tvalid=%0b tdata=%h held=%h", name, sm_tvalid, sm_tdata, held);
                        end
                    end
                    sm_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (sm_tvalid && sm_tready) begin
                        chk($sformatf("%s_y%0d", name, got), sm_tdata, yq[got]);
                        chk($sformatf("%s_last%0d", name, got), {31'b0, sm_tlast}, {31'b0, got == n - 1});
                        got++;
                        stall = 1'b0;
                    end else begin
                        stall = sm_tvalid;
                        held  = sm_tdata;
                    end
                end
                if (got < n) tmo({name, "_collect"});
                @(negedge axis_clk);
                sm_tready = 1'b0;
            end
        join
        wait_done({name, "_status"});
    endtask

    task automatic run_stream(input bit bp, input string name);
        axi_write(12'h010, 32'(xq.size()));
        axi_write(12'h000, 32'h1);
        stream_only(bp, name);
    endtask

    task automatic feed_one(input logic [31:0] x);
        int c = 0;
        @(negedge axis_clk);
        ss_tvalid = 1'b1; ss_tdata = x;
        while (!ss_tready && c < 40) begin @(negedge axis_clk); c++; end
        if (!ss_tready) tmo("feed_one");
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
    endtask

    task automatic wait_out();
        int c = 0;
        while (!sm_tvalid && c < 40) begin @(negedge axis_clk); c++; end
        if (!sm_tvalid) tmo("wait_out");
    endtask

    task automatic set_impulse();
        xq.delete(); yq.delete();
        for (int i = 0; i < 12; i++) begin
            xq.push_back(i == 0 ? 32'd1 : 32'd0);
            yq.push_back(32'(imp_exp[i]));
        end
    endtask

    initial begin
        logic [31:0] rd;
        bit seen_ready;

        repeat (2) @(negedge axis_clk);
        chk("rst_ss_tready", {31'b0, ss_tready}, 32'h0);
        chk("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'h0);
        chk("rst_sm_tdata", sm_tdata, 32'h0);
        chk("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_sram", {22'b0, tap_WE, data_WE, tap_EN, data_EN}, 32'h0);
        axis_rst_n = 1'b1;

        for (int k = 0; k < NT; k++)
            vec.push_back('{1'b1, 12'(32 + 4 * k), 32'(tap_int[k]), 32'h0});
        for (int k = 0; k < NT; k++)
            vec.push_back('{1'b0, 12'(32 + 4 * k), 32'h0, 32'(tap_int[k])});
        vec.push_back('{1'b0, 12'h000, 32'h0, 32'h4});
        vec.push_back('{1'b0, 12'h010, 32'h0, 32'h0});
        vec.push_back('{1'b1, 12'h010, 32'd600, 32'h0});
        vec.push_back('{1'b0, 12'h010, 32'h0, 32'd600});
        vec.push_back('{1'b1, 12'h014, 32'h7, 32'h0});
        vec.push_back('{1'b0, 12'h014, 32'h0, 32'h0});
        vec.push_back('{1'b0, 12'h04C, 32'h0, 32'h0});
        vec.push_back('{1'b1, 12'h000, 32'h0, 32'h0});
        vec.push_back('{1'b0, 12'h000, 32'h0, 32'h4});
        foreach (vec[i]) begin
            if (vec[i].wr) axi_write(vec[i].addr, vec[i].data);
            else begin
                axi_read(vec[i].addr, rd);
                chk($sformatf("reg_%03h", vec[i].addr), rd, vec[i].exp);
            end
        end

        // Samples offered while idle must stall.
        seen_ready = 1'b0;
        @(negedge axis_clk);
        ss_tvalid = 1'b1; ss_tdata = 32'h5;
        repeat (12) begin @(negedge axis_clk); seen_ready |= ss_tready; end
        chk("prestart_stall", {31'b0, seen_ready}, 32'h0);
        ss_tvalid = 1'b0;

        set_impulse();
        run_stream(1'b0, "impulse");

        xq = '{32'd5, 32'hFFFF_FFFE, 32'd7};
        build_expected();
        axi_write(12'h010, 32'd3);
        axi_write(12'h000, 32'h1);
        axi_read(12'h020, rd);
        chk("busy_tap_read", rd, 32'hFFFF_FFFF);
        axi_write(12'h010, 32'd99);
        axi_write(12'h024, 32'd1234);
        axi_read(12'h010, rd);
        chk("busy_len_write_ignored", rd, 32'd3);
        axi_read(12'h000, rd);
        chk("busy_status", rd, 32'h0);
        stream_only(1'b0, "short");
        axi_read(12'h024, rd);
        chk("busy_tap_write_ignored", rd, 32'hFFFF_FFF6);

        xq = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
        for (int i = 0; i < 9; i++) xq.push_back($urandom);
        build_expected();
        run_stream(1'b1, "wrap");

        axi_write(12'h010, 32'd0);
        axi_write(12'h000, 32'h1);
        wait_done("len0_status");

        axi_write(12'h010, 32'd20);
        axi_write(12'h000, 32'h1);
        sm_tready = 1'b0;
        feed_one(32'd3);
        wait_out();
        chk("mid_y0", sm_tdata, 32'h0);
        @(negedge axis_clk); sm_tready = 1'b1;
        @(negedge axis_clk); sm_tready = 1'b0;
        feed_one(32'd5);
        wait_out();
        chk("mid_y1", sm_tdata, 32'hFFFF_FFE2);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        chk("mid_rst_sm_tvalid", {31'b0, sm_tvalid}, 32'h0);
        chk("mid_rst_sm_tdata", sm_tdata, 32'h0);
        chk("mid_rst_ss_tready", {31'b0, ss_tready}, 32'h0);
        chk("mid_rst_sram_en", {30'b0, tap_EN, data_EN}, 32'h0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        axi_read(12'h000, rd);
        chk("mid_rst_status", rd, 32'h4);
        axi_read(12'h010, rd);
        chk("mid_rst_len", rd, 32'h0);
        axi_read(12'h02C, rd);
        chk("mid_rst_tap_kept", rd, 32'd23);
        set_impulse();
        run_stream(1'b0, "rerun");

        xq.delete();
        for (int i = 0; i < 600; i++) begin
            int p = i % 40;
            xq.push_back(32'((p < 20 ? p : 40 - p) - 10));
        end
        build_expected();
        run_stream(1'b1, "tri600");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
